// File: rtl/recip_estimate_rom_if.sv
// recip_estimate_rom_if: lookup request/response bundle for the reciprocal seed table
interface recip_estimate_rom_if #(parameter int LUT_WIDTH = 6);
  logic                 en_i;
  logic [LUT_WIDTH-1:0] addr_i;
  logic [LUT_WIDTH-1:0] data_o;
  logic                 valid_o;
  modport master (output en_i, addr_i, input data_o, valid_o);
  modport slave (input en_i, addr_i, output data_o, valid_o);
endinterface

// File: rtl/recip_estimate_rom.sv
// recip_estimate_rom: registered 64-entry table of the 6-bit fraction of 2/(1.f)
module recip_estimate_rom #(parameter int LUT_WIDTH = 6) (
  input logic clk,
  input logic reset,
  recip_estimate_rom_if.slave bus
);
  localparam int N = 2 ** LUT_WIDTH;
  logic [LUT_WIDTH-1:0] rom [N];
  logic [LUT_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  // entry 0 would be exactly 2.0, which needs a 7th bit, so it saturates
  for (genvar i = 0; i < N; i++) begin : g_rom
    assign rom[i] = (i == 0) ? '1 : LUT_WIDTH'((2 * N * N) / (N + i) - N);
  end
  always_comb begin
    data_d  = bus.en_i ? rom[bus.addr_i] : data_q;
    valid_d = bus.en_i;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
endmodule

// File: tb/tb_recip_estimate_rom.sv
// tb_recip_estimate_rom: directed vector table, full sweep and consumer bound check
module tb_recip_estimate_rom;
  typedef struct {
    logic       rst;
    logic       en;
    logic [5:0] addr;
    logic [5:0] exp_d;
    logic       exp_v;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  vec_t vecs [$];
  logic [5:0] got [64];
  recip_estimate_rom_if #(.LUT_WIDTH(6)) bus ();
  recip_estimate_rom #(.LUT_WIDTH(6)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic e, input logic [5:0] a);
    @(negedge clk);
    reset = r;
    bus.en_i = e;
    bus.addr_i = a;
    @(posedge clk);
    #1;
  endtask
  function automatic int model(input int a);
    return (a == 0) ? 63 : 8192 / (64 + a) - 64;
  endfunction
  initial begin
    bus.en_i = 1'b1;
    bus.addr_i = 6'd5;
    vecs = '{
      '{1'b1, 1'b1, 6'd5,  6'd0,  1'b0},
      '{1'b1, 1'b1, 6'd5,  6'd0,  1'b0},
      '{1'b0, 1'b1, 6'd5,  6'd54, 1'b1},
      '{1'b0, 1'b1, 6'd0,  6'd63, 1'b1},
      '{1'b0, 1'b1, 6'd1,  6'd62, 1'b1},
      '{1'b0, 1'b1, 6'd2,  6'd60, 1'b1},
      '{1'b0, 1'b1, 6'd31, 6'd22, 1'b1},
      '{1'b0, 1'b1, 6'd32, 6'd21, 1'b1},
      '{1'b0, 1'b1, 6'd48, 6'd9,  1'b1},
      '{1'b0, 1'b1, 6'd62, 6'd1,  1'b1},
      '{1'b0, 1'b1, 6'd63, 6'd0,  1'b1},
      '{1'b0, 1'b1, 6'd16, 6'd38, 1'b1},
      '{1'b0, 1'b0, 6'd0,  6'd38, 1'b0},
      '{1'b0, 1'b0, 6'd63, 6'd38, 1'b0},
      '{1'b0, 1'b0, 6'd40, 6'd38, 1'b0},
      '{1'b0, 1'b1, 6'd2,  6'd60, 1'b1},
      '{1'b1, 1'b1, 6'd31, 6'd0,  1'b0},
      '{1'b0, 1'b1, 6'd48, 6'd9,  1'b1}
    };
    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].en, vecs[k].addr);
      check($sformatf("vec%0d data", k), int'(bus.data_o), int'(vecs[k].exp_d));
      check($sformatf("vec%0d valid", k), int'(bus.valid_o), int'(vecs[k].exp_v));
    end
    for (int a = 0; a < 64; a++) begin
      step(1'b0, 1'b1, 6'(a));
      got[a] = bus.data_o;
      check($sformatf("sweep%0d data", a), int'(bus.data_o), model(a));
      check($sformatf("sweep%0d valid", a), int'(bus.valid_o), 1);
    end
    check("a0 saturated", int'(got[0]), 63);
    for (int a = 1; a < 64; a++) begin
      int p;
      p = (64 + int'(got[a])) * (64 + a);
      check($sformatf("upper%0d", a), int'(p <= 8192), 1);
      check($sformatf("lower%0d", a), int'(p >= 8192 - (64 + a)), 1);
      check($sformatf("mono%0d", a), int'(got[a] <= got[a-1]), 1);
    end
    step(1'b0, 1'b0, 6'd7);
    check("idle valid", int'(bus.valid_o), 0);
    check("idle hold", int'(bus.data_o), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
